alu_feeder: RTL and testbench
=============================

// Module: alu_feeder
// PURPOSE
//  Issue stage directly upstream of the 4-bit ALU (operador). Buffers {instr,A,B} operation requests in a FIFO.
//  Presents one request at a time on stable ALU inputs and holds them for the ALU's fixed latency.
//  Then pulses res_valid so downstream logic samples the ALU's dato_mux exactly once per operation.
// PARAMETERS
//  DEPTH    4  FIFO entries; power of two, >=2
//  ALU_LAT  3  cycles from operands stable to dato_mux valid (operand reg -> result reg -> mux reg); >=1
//  DATA_W   4  operand width
//  INSTR_W  8  instruction width; opcode is instr[7:5], bits [4:0] pass through unchanged
// PORTS
//  clk        in   1        single clock, all state on rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        request present on in_instr/in_a/in_b
//  in_ready   out  1        FIFO can accept; push = in_valid & in_ready
//  in_instr   in   INSTR_W  instruction to issue
//  in_a       in   DATA_W   operand A
//  in_b       in   DATA_W   operand B
//  flush      in   1        synchronous: discard all queued (not in-flight) entries
//  instr      out  INSTR_W  to ALU instr
//  A          out  DATA_W   to ALU A
//  B          out  DATA_W   to ALU B
//  busy       out  1        operation in flight (state EXEC)
//  res_valid  out  1        one-cycle pulse: ALU result for the last issued op is valid this cycle
//  level      out  log2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (async): FIFO empty, level=0, in_ready=1, instr=A=B=0, busy=0, res_valid=0, state IDLE.
//    Reset mid-EXEC abandons the op with no res_valid.
//  FIFO: circular, rd/wr pointers with wrap at DEPTH; in_ready = (level != DEPTH), registered-state based.
//    Push and pop in the same cycle: level unchanged; when full, in_ready=0 so no push that cycle even if popping.
//  FSM IDLE: if level!=0 and !flush -> pop head into instr/A/B registers, cnt=ALU_LAT-1, go EXEC.
//  FSM EXEC: busy=1; instr/A/B held constant; cnt decrements each cycle.
//    When cnt==0: res_valid=1 for that cycle, return to IDLE.
//  Issue-to-res_valid latency = ALU_LAT cycles after the cycle instr/A/B change.
//  Peak throughput: one op per ALU_LAT+1 cycles.
//  Back-to-back: the IDLE cycle after res_valid may pop the next entry; instr/A/B update only on pop,
//    otherwise they keep the last issued values.
//  flush: level->0, pointers equalised; in-flight op completes normally; a push in the same cycle as flush is dropped.
//  Opcode field is not decoded; all 8 opcodes (0..7) issue identically.
//  Arithmetic: level and pointers are unsigned; pointers use log2(DEPTH) bits and wrap naturally.
// CONFIGURATION
//  ALU_FEED_STATS_EN defined:
//    adds output op_count[15:0], reset 0, +1 on every res_valid pulse, wraps 0xFFFF->0.
//    adds output drop_count[7:0], reset 0, +1 per cycle with in_valid & !in_ready, saturates at 0xFF.
//  ALU_FEED_STATS_EN undefined: neither port nor its counters exist; all other behaviour identical.
// TESTING
//  1 Reset: assert rst mid-cycle -> all outputs 0, in_ready=1, level=0 immediately (before next edge).
//  2 Single op: push {instr=8'h00,a=4'h3,b=4'h4} -> A=3,B=4 next edge;
//    res_valid exactly ALU_LAT=3 cycles later; ALU dato_mux=4'h7 that cycle.
//  3 Fill: push 5 ops with DEPTH=4, ALU stalled in EXEC -> in_ready=0 at level 4, 5th held by source;
//    ops issue in FIFO order (opcodes 0,1,2,3,4), one res_valid per op.
//  4 Simultaneous push/pop at level 1 -> level stays 1; popped op is the older one; pointer wrap after 4+ pushes is correct.
//  5 flush during EXEC with level=3 -> in-flight res_valid still fires once, level=0, no further issue.
//  6 Reset during EXEC (cnt=1) -> no res_valid ever for that op; next pushed op issues normally;
//    with ALU_FEED_STATS_EN, op_count counts only completed ops and drop_count counts refused cycles.

Source files
------------

// File: rtl/alu_feeder.sv
// Issue stage in front of the 4-bit ALU: queues {instr,A,B} requests and holds each one steady for ALU_LAT cycles.
// Defining ALU_FEED_STATS_EN adds the op_count/drop_count statistics outputs.
module alu_feeder #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 3,
  parameter int DATA_W  = 4,
  parameter int INSTR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic [DATA_W-1:0]        in_a,
  input  logic [DATA_W-1:0]        in_b,
  input  logic                     flush,
  output logic [INSTR_W-1:0]       instr,
  output logic [DATA_W-1:0]        A,
  output logic [DATA_W-1:0]        B,
  output logic                     busy,
  output logic                     res_valid,
  output logic [$clog2(DEPTH):0]   level
`ifdef ALU_FEED_STATS_EN
  ,
  output logic [15:0]              op_count,
  output logic [7:0]               drop_count
`endif
);

  // state | meaning
  // IDLE  | no op in flight; pops the FIFO head whenever one is queued and no flush
  // EXEC  | op in flight; instr/A/B frozen while cnt counts down to the result cycle
  typedef enum logic {ST_IDLE, ST_EXEC} state_t;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [INSTR_W-1:0]   instr_q;
  logic [DATA_W-1:0]    a_q;
  logic [DATA_W-1:0]    b_q;

  logic [INSTR_W-1:0]   fifo_instr_q [DEPTH];
  logic [DATA_W-1:0]    fifo_a_q     [DEPTH];
  logic [DATA_W-1:0]    fifo_b_q     [DEPTH];

  logic                 push;
  logic                 pop;

  assign in_ready = (level_q != LVL_FULL);
  assign push     = in_valid & in_ready & ~flush;
  assign level    = level_q;
  assign instr    = instr_q;
  assign A        = a_q;
  assign B        = b_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop       = 1'b0;
    busy      = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((level_q != '0) && !flush) begin
          pop     = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          res_valid = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  // flush only empties the queue; the op already latched in instr/A/B still runs to completion
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = rd_ptr_q;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_q[i] <= '0;
        fifo_a_q[i]     <= '0;
        fifo_b_q[i]     <= '0;
      end
    end else if (push) begin
      fifo_instr_q[wr_ptr_q] <= in_instr;
      fifo_a_q[wr_ptr_q]     <= in_a;
      fifo_b_q[wr_ptr_q]     <= in_b;
    end
  end

  // ALU inputs change only on a pop, so the ALU sees them stable for the whole op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (pop) begin
      instr_q <= fifo_instr_q[rd_ptr_q];
      a_q     <= fifo_a_q[rd_ptr_q];
      b_q     <= fifo_b_q[rd_ptr_q];
    end
  end

`ifdef ALU_FEED_STATS_EN
  logic [15:0] op_count_q;
  logic [7:0]  drop_count_q;

  assign op_count   = op_count_q;
  assign drop_count = drop_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      if (res_valid)
        op_count_q <= op_count_q + 16'd1;
      if (in_valid && !in_ready && (drop_count_q != 8'hFF))
        drop_count_q <= drop_count_q + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_feeder.sv
// Directed bench for alu_feeder: vector table for fill/order/wrap, hand sequences for flush and reset-in-flight.
// Statistics checks are compiled in when ALU_FEED_STATS_EN is defined.
module tb_alu_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_instr;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       flush;
  logic [7:0] instr;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       res_valid;
  logic [2:0] level;
`ifdef ALU_FEED_STATS_EN
  logic [15:0] op_count;
  logic [7:0]  drop_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_a      (in_a),
    .in_b      (in_b),
    .flush     (flush),
    .instr     (instr),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .res_valid (res_valid),
    .level     (level)
`ifdef ALU_FEED_STATS_EN
    ,
    .op_count  (op_count),
    .drop_count(drop_count)
`endif
  );

  typedef struct {
    logic       vld;
    logic [7:0] ins;
    logic [3:0] a;
    logic [3:0] b;
    logic       e_rdy;
    logic [2:0] e_lvl;
    logic       e_busy;
    logic       e_rv;
    logic [7:0] e_ins;
    logic [3:0] e_a;
    logic [3:0] e_b;
  } vec_t;

  vec_t vt [26];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] ins, input logic [3:0] a,
                     input logic [3:0] b, input logic fl);
    in_valid = v;
    in_instr = ins;
    in_a     = a;
    in_b     = b;
    flush    = fl;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  int rv_seen;

  initial begin
    // ops: S(00,3,4) op0(05,1,2) op1(2A,3,5) op2(4F,7,8) op3(71,9,A) op4(9C,B,C)
    vt[0]  = '{1'b1, 8'h00, 4'h3, 4'h4, 1'b1, 3'd1, 1'b0, 1'b0, 8'h00, 4'h0, 4'h0};
    vt[1]  = '{1'b1, 8'h05, 4'h1, 4'h2, 1'b1, 3'd1, 1'b1, 1'b0, 8'h00, 4'h3, 4'h4};
    vt[2]  = '{1'b1, 8'h2A, 4'h3, 4'h5, 1'b1, 3'd2, 1'b1, 1'b0, 8'h00, 4'h3, 4'h4};
    vt[3]  = '{1'b1, 8'h4F, 4'h7, 4'h8, 1'b1, 3'd3, 1'b1, 1'b1, 8'h00, 4'h3, 4'h4};
    vt[4]  = '{1'b1, 8'h71, 4'h9, 4'hA, 1'b0, 3'd4, 1'b0, 1'b0, 8'h00, 4'h3, 4'h4};
    vt[5]  = '{1'b1, 8'h9C, 4'hB, 4'hC, 1'b1, 3'd3, 1'b1, 1'b0, 8'h05, 4'h1, 4'h2};
    vt[6]  = '{1'b1, 8'h9C, 4'hB, 4'hC, 1'b0, 3'd4, 1'b1, 1'b0, 8'h05, 4'h1, 4'h2};
    vt[7]  = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 3'd4, 1'b1, 1'b1, 8'h05, 4'h1, 4'h2};
    vt[8]  = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 3'd4, 1'b0, 1'b0, 8'h05, 4'h1, 4'h2};
    vt[9]  = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd3, 1'b1, 1'b0, 8'h2A, 4'h3, 4'h5};
    vt[10] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd3, 1'b1, 1'b0, 8'h2A, 4'h3, 4'h5};
    vt[11] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd3, 1'b1, 1'b1, 8'h2A, 4'h3, 4'h5};
    vt[12] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd3, 1'b0, 1'b0, 8'h2A, 4'h3, 4'h5};
    vt[13] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd2, 1'b1, 1'b0, 8'h4F, 4'h7, 4'h8};
    vt[14] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd2, 1'b1, 1'b0, 8'h4F, 4'h7, 4'h8};
    vt[15] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd2, 1'b1, 1'b1, 8'h4F, 4'h7, 4'h8};
    vt[16] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd2, 1'b0, 1'b0, 8'h4F, 4'h7, 4'h8};
    vt[17] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd1, 1'b1, 1'b0, 8'h71, 4'h9, 4'hA};
    vt[18] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd1, 1'b1, 1'b0, 8'h71, 4'h9, 4'hA};
    vt[19] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd1, 1'b1, 1'b1, 8'h71, 4'h9, 4'hA};
    vt[20] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd1, 1'b0, 1'b0, 8'h71, 4'h9, 4'hA};
    vt[21] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd0, 1'b1, 1'b0, 8'h9C, 4'hB, 4'hC};
    vt[22] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd0, 1'b1, 1'b0, 8'h9C, 4'hB, 4'hC};
    vt[23] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd0, 1'b1, 1'b1, 8'h9C, 4'hB, 4'hC};
    vt[24] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h9C, 4'hB, 4'hC};
    vt[25] = '{1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 3'd0, 1'b0, 1'b0, 8'h9C, 4'hB, 4'hC};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    in_a     = '0;
    in_b     = '0;
    flush    = 1'b0;
    #2;
    chk("rst_level", level, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy",  busy, 0);
    chk("rst_rv",    res_valid, 0);
    chk("rst_ABI",   {instr, A, B}, 0);
    @(negedge clk);
    rst = 1'b0;

    // single op, fill with stalled ALU, order, push/pop at level 1, pointer wrap
    for (int i = 0; i < 26; i++) begin
      cyc(vt[i].vld, vt[i].ins, vt[i].a, vt[i].b, 1'b0);
      chk($sformatf("v%0d_ready", i), in_ready,  vt[i].e_rdy);
      chk($sformatf("v%0d_level", i), level,     vt[i].e_lvl);
      chk($sformatf("v%0d_busy",  i), busy,      vt[i].e_busy);
      chk($sformatf("v%0d_rv",    i), res_valid, vt[i].e_rv);
      chk($sformatf("v%0d_instr", i), instr,     vt[i].e_ins);
      chk($sformatf("v%0d_A",     i), A,         vt[i].e_a);
      chk($sformatf("v%0d_B",     i), B,         vt[i].e_b);
    end
`ifdef ALU_FEED_STATS_EN
    chk("tbl_op_count",   op_count, 6);
    chk("tbl_drop_count", drop_count, 1);
`endif

    // flush while X1 executes with three entries queued
    cyc(1'b1, 8'h10, 4'h1, 4'h1, 1'b0);
    cyc(1'b1, 8'h32, 4'h2, 4'h3, 1'b0);
    cyc(1'b1, 8'h54, 4'h4, 4'h4, 1'b0);
    cyc(1'b1, 8'h76, 4'h5, 4'h6, 1'b0);
    cyc(1'b1, 8'hF8, 4'h7, 4'h7, 1'b0);
    chk("fl_full", level, 4);
    cyc(1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
    chk("fl_pre_level", level, 3);
    chk("fl_pre_busy",  busy, 1);
    chk("fl_pre_instr", instr, 8'h32);
    rv_seen = 0;
    cyc(1'b1, 8'hE9, 4'h8, 4'h8, 1'b1);
    chk("fl_level0", level, 0);
    chk("fl_ready",  in_ready, 1);
    chk("fl_busy",   busy, 1);
    if (res_valid) rv_seen++;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
      if (res_valid) rv_seen++;
      chk($sformatf("fl_post%0d_level", i), level, 0);
    end
    chk("fl_rv_once",  rv_seen, 1);
    chk("fl_no_issue", busy, 0);
    chk("fl_held",     {instr, A, B}, {8'h32, 4'h2, 4'h3});
`ifdef ALU_FEED_STATS_EN
    chk("fl_op_count",   op_count, 8);
    chk("fl_drop_count", drop_count, 1);
`endif

    // reset while the op is in flight with cnt=1
    cyc(1'b1, 8'hE7, 4'h6, 4'h9, 1'b0);
    cyc(1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
    chk("rx_issue_A", A, 4'h6);
    cyc(1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
    chk("rx_cnt1_busy", busy, 1);
    chk("rx_cnt1_rv",   res_valid, 0);
    rst = 1'b1;
    #1;
    chk("rx_level", level, 0);
    chk("rx_ready", in_ready, 1);
    chk("rx_busy",  busy, 0);
    chk("rx_rv",    res_valid, 0);
    chk("rx_ABI",   {instr, A, B}, 0);
`ifdef ALU_FEED_STATS_EN
    chk("rx_op_count",   op_count, 0);
    chk("rx_drop_count", drop_count, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    rv_seen = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
      if (res_valid || busy) rv_seen++;
    end
    chk("rx_abandoned", rv_seen, 0);
    cyc(1'b1, 8'h63, 4'h2, 4'h5, 1'b0);
    chk("rx_z_level", level, 1);
    cyc(1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
    chk("rx_z_issue", {instr, A, B}, {8'h63, 4'h2, 4'h5});
    cyc(1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
    chk("rx_z_wait", res_valid, 0);
    cyc(1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
    chk("rx_z_rv", res_valid, 1);
    cyc(1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
    chk("rx_z_done", {busy, res_valid}, 2'b00);
`ifdef ALU_FEED_STATS_EN
    chk("rx_z_op_count",   op_count, 1);
    chk("rx_z_drop_count", drop_count, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
